// File: rtl/cpu_perf_monitor.sv
// rtl/cpu_perf_monitor.sv - cycle/event counters with periodic snapshots and PC-stall hang detection
module cpu_perf_monitor #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int SAMPLE_W   = 16,
    parameter int PC_W       = 32,
    parameter int HANG_LIMIT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic [PC_W-1:0]          pc_in,
    input  logic [NUM_EVT-1:0]       evt_in,
    input  logic [SAMPLE_W-1:0]      sample_period,
    output logic                     snap_valid,
    input  logic                     snap_ready,
    output logic [CNT_W-1:0]         snap_cycle,
    output logic [PC_W-1:0]          snap_pc,
    output logic [NUM_EVT*CNT_W-1:0] snap_evt,
    output logic                     snap_overflow,
    output logic                     hang,
    output logic [PC_W-1:0]          hang_pc
);

    localparam int STALL_W = $clog2(HANG_LIMIT);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(HANG_LIMIT - 1);

    typedef enum logic {S_RUN, S_HOLD} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cycle_q, cycle_d;
    logic [NUM_EVT*CNT_W-1:0]   evt_q, evt_d;
    logic [SAMPLE_W-1:0]        sample_cnt_q, sample_cnt_d;
    logic [STALL_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]            prev_pc_q, prev_pc_d;
    logic                       pc_valid_q, pc_valid_d;
    logic [CNT_W-1:0]           snap_cycle_q, snap_cycle_d;
    logic [PC_W-1:0]            snap_pc_q, snap_pc_d;
    logic [NUM_EVT*CNT_W-1:0]   snap_evt_q, snap_evt_d;
    logic                       snap_overflow_q, snap_overflow_d;
    logic                       hang_q, hang_d;
    logic [PC_W-1:0]            hang_pc_q, hang_pc_d;

    logic handshake;
    logic boundary;
    logic stall;

    always_comb begin
        handshake = (state_q == S_HOLD) && snap_ready;
        boundary  = en && (sample_period != '0) &&
                    (sample_cnt_q == sample_period - SAMPLE_W'(1));
        stall     = en && pc_valid_q && (pc_in == prev_pc_q);

        cycle_d = en ? cycle_q + CNT_W'(1) : cycle_q;
        evt_d   = evt_q;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (en && evt_in[i] && (evt_q[i*CNT_W +: CNT_W] != '1)) begin
                evt_d[i*CNT_W +: CNT_W] = evt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end

        // A shrunken period can leave the counter past its new end; restart it.
        if ((sample_period == '0) || (sample_cnt_q >= sample_period)) begin
            sample_cnt_d = '0;
        end else if (en) begin
            sample_cnt_d = boundary ? '0 : sample_cnt_q + SAMPLE_W'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        prev_pc_d  = en ? pc_in : prev_pc_q;
        pc_valid_d = pc_valid_q | en;
        if (!en) begin
            stall_cnt_d = stall_cnt_q;
        end else if (stall) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
        end else begin
            stall_cnt_d = '0;
        end

        hang_d    = hang_q;
        hang_pc_d = hang_pc_q;
        if (stall && (stall_cnt_q == STALL_MAX) && !hang_q) begin
            hang_d    = 1'b1;
            hang_pc_d = pc_in;
        end

        state_d         = state_q;
        snap_cycle_d    = snap_cycle_q;
        snap_pc_d       = snap_pc_q;
        snap_evt_d      = snap_evt_q;
        snap_overflow_d = snap_overflow_q;
        if (boundary && ((state_q == S_RUN) || handshake)) begin
            state_d      = S_HOLD;
            snap_cycle_d = cycle_d;
            snap_pc_d    = pc_in;
            snap_evt_d   = evt_d;
        end else if (boundary) begin
            snap_overflow_d = 1'b1;
        end else if (handshake) begin
            state_d = S_RUN;
        end

        if (clear) begin
            state_d         = S_RUN;
            cycle_d         = '0;
            evt_d           = '0;
            sample_cnt_d    = '0;
            stall_cnt_d     = '0;
            prev_pc_d       = '0;
            pc_valid_d      = 1'b0;
            snap_cycle_d    = '0;
            snap_pc_d       = '0;
            snap_evt_d      = '0;
            snap_overflow_d = 1'b0;
            hang_d          = 1'b0;
            hang_pc_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_RUN;
            cycle_q         <= '0;
            evt_q           <= '0;
            sample_cnt_q    <= '0;
            stall_cnt_q     <= '0;
            prev_pc_q       <= '0;
            pc_valid_q      <= 1'b0;
            snap_cycle_q    <= '0;
            snap_pc_q       <= '0;
            snap_evt_q      <= '0;
            snap_overflow_q <= 1'b0;
            hang_q          <= 1'b0;
            hang_pc_q       <= '0;
        end else begin
            state_q         <= state_d;
            cycle_q         <= cycle_d;
            evt_q           <= evt_d;
            sample_cnt_q    <= sample_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            prev_pc_q       <= prev_pc_d;
            pc_valid_q      <= pc_valid_d;
            snap_cycle_q    <= snap_cycle_d;
            snap_pc_q       <= snap_pc_d;
            snap_evt_q      <= snap_evt_d;
            snap_overflow_q <= snap_overflow_d;
            hang_q          <= hang_d;
            hang_pc_q       <= hang_pc_d;
        end
    end

    assign snap_valid    = (state_q == S_HOLD);
    assign snap_cycle    = snap_cycle_q;
    assign snap_pc       = snap_pc_q;
    assign snap_evt      = snap_evt_q;
    assign snap_overflow = snap_overflow_q;
    assign hang          = hang_q;
    assign hang_pc       = hang_pc_q;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// tb/tb_cpu_perf_monitor.sv - bench for cpu_perf_monitor: 32-bit and 4-bit counter instances against a reference model
module tb_cpu_perf_monitor;

    localparam int HL = 8;

    logic        clk = 1'b0;
    logic        rst, clr, en, snap_ready;
    logic [31:0] pc;
    logic [3:0]  evt;
    logic [15:0] period;
    bit          pc_hold;

    logic         a_valid, a_ovf, a_hang;
    logic [31:0]  a_cycle, a_pc, a_hang_pc;
    logic [127:0] a_evt;
    logic         b_valid, b_ovf, b_hang;
    logic [3:0]   b_cycle;
    logic [31:0]  b_pc, b_hang_pc;
    logic [15:0]  b_evt;

    always #5 clk = ~clk;

    cpu_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .SAMPLE_W(16), .PC_W(32), .HANG_LIMIT(HL)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clear(clr), .pc_in(pc), .evt_in(evt),
        .sample_period(period), .snap_valid(a_valid), .snap_ready(snap_ready),
        .snap_cycle(a_cycle), .snap_pc(a_pc), .snap_evt(a_evt),
        .snap_overflow(a_ovf), .hang(a_hang), .hang_pc(a_hang_pc)
    );

    cpu_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SAMPLE_W(16), .PC_W(32), .HANG_LIMIT(HL)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clear(clr), .pc_in(pc), .evt_in(evt),
        .sample_period(period), .snap_valid(b_valid), .snap_ready(snap_ready),
        .snap_cycle(b_cycle), .snap_pc(b_pc), .snap_evt(b_evt),
        .snap_overflow(b_ovf), .hang(b_hang), .hang_pc(b_hang_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the 32-bit instance, index 1 the 4-bit one.
    longint m_cycle [2];
    longint m_evt [2][4];
    longint m_snap_cycle [2];
    longint m_snap_evt [2][4];
    bit     m_valid, m_ovf, m_hang, m_have_pc;
    longint m_snap_pc, m_hang_pc, m_prev_pc;
    int     m_sc, m_run;

    function automatic longint cmax(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    task automatic model_step();
        bit hs, bnd;
        if (!rst || clr) begin
            for (int k = 0; k < 2; k++) begin
                m_cycle[k] = 0;
                m_snap_cycle[k] = 0;
                for (int i = 0; i < 4; i++) begin
                    m_evt[k][i] = 0;
                    m_snap_evt[k][i] = 0;
                end
            end
            m_valid = 0; m_ovf = 0; m_hang = 0; m_have_pc = 0;
            m_snap_pc = 0; m_hang_pc = 0; m_prev_pc = 0; m_sc = 0; m_run = 0;
            return;
        end
        hs  = m_valid && snap_ready;
        bnd = en && (period != 0) && (m_sc == int'(period) - 1);
        if (en) begin
            for (int k = 0; k < 2; k++) begin
                m_cycle[k] = (m_cycle[k] + 1) % (cmax(k) + 1);
                for (int i = 0; i < 4; i++)
                    if (evt[i] && m_evt[k][i] < cmax(k)) m_evt[k][i]++;
            end
        end
        if (period == 0 || m_sc >= int'(period)) m_sc = 0;
        else if (en) m_sc = bnd ? 0 : m_sc + 1;
        if (bnd) begin
            if (!m_valid || hs) begin
                m_valid = 1;
                m_snap_pc = pc;
                for (int k = 0; k < 2; k++) begin
                    m_snap_cycle[k] = m_cycle[k];
                    for (int i = 0; i < 4; i++) m_snap_evt[k][i] = m_evt[k][i];
                end
            end else begin
                m_ovf = 1;
            end
        end else if (hs) begin
            m_valid = 0;
        end
        if (en) begin
            if (m_have_pc && pc == m_prev_pc) begin
                m_run++;
                if (m_run == HL && !m_hang) begin
                    m_hang = 1;
                    m_hang_pc = pc;
                end
            end else begin
                m_run = 0;
            end
            m_prev_pc = pc;
            m_have_pc = 1;
        end
    endtask

    task automatic compare_all();
        chk("a_valid", a_valid, m_valid);
        chk("a_cycle", a_cycle, m_snap_cycle[0]);
        chk("a_pc", a_pc, m_snap_pc);
        chk("a_ovf", a_ovf, m_ovf);
        chk("a_hang", a_hang, m_hang);
        chk("a_hang_pc", a_hang_pc, m_hang_pc);
        chk("b_valid", b_valid, m_valid);
        chk("b_cycle", b_cycle, m_snap_cycle[1]);
        chk("b_pc", b_pc, m_snap_pc);
        chk("b_ovf", b_ovf, m_ovf);
        chk("b_hang", b_hang, m_hang);
        chk("b_hang_pc", b_hang_pc, m_hang_pc);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_evt%0d", i), a_evt[i*32 +: 32], m_snap_evt[0][i]);
            chk($sformatf("b_evt%0d", i), b_evt[i*4 +: 4], m_snap_evt[1][i]);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!pc_hold) pc = pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; en = 1'b0; snap_ready = 1'b0;
        pc = 32'h1000; evt = 4'h0; period = 16'd0; pc_hold = 1'b0;
        cyc(3);
        chk("lit_reset_valid", a_valid, 0);
        chk("lit_reset_hang", a_hang, 0);

        // period 100, ch0 every cycle
        rst = 1'b1; en = 1'b1; snap_ready = 1'b1; evt = 4'b0001; period = 16'd100;
        cyc(100);
        chk("lit_p100_valid", a_valid, 1);
        chk("lit_p100_cycle", a_cycle, 100);
        chk("lit_p100_ch0", a_evt[31:0], 100);
        cyc(100);
        chk("lit_p100_cycle2", a_cycle, 200);

        // reset mid-run
        rst = 1'b0;
        cyc(1);
        chk("lit_midrst_valid", a_valid, 0);
        chk("lit_midrst_cycle", a_cycle, 0);
        chk("lit_midrst_ch0", a_evt[31:0], 0);
        cyc(2);

        // overflow while consumer stalls
        rst = 1'b1; period = 16'd10; snap_ready = 1'b0; evt = 4'b0101;
        cyc(25);
        chk("lit_ovf_flag", a_ovf, 1);
        chk("lit_ovf_held_cycle", a_cycle, 10);
        chk("lit_ovf_held_ch2", a_evt[95:64], 10);
        snap_ready = 1'b1;
        cyc(5);
        chk("lit_ovf_next_valid", a_valid, 1);
        chk("lit_ovf_next_cycle", a_cycle, 30);

        // narrow counters: saturation and wrap
        clr = 1'b1; period = 16'd20; evt = 4'b0010;
        cyc(1);
        chk("lit_clr_ovf", a_ovf, 0);
        clr = 1'b0;
        cyc(20);
        chk("lit_w4_cycle", b_cycle, 4);
        chk("lit_w4_ch1", b_evt[7:4], 15);
        chk("lit_w32_ch1", a_evt[63:32], 20);

        // clear on the boundary cycle
        clr = 1'b1; period = 16'd10;
        cyc(1);
        clr = 1'b0;
        cyc(9);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("lit_bclr_valid", a_valid, 0);
        cyc(10);
        chk("lit_bclr_restart", a_cycle, 10);

        // hang detection
        clr = 1'b1; period = 16'd0; pc_hold = 1'b1; pc = 32'h80;
        cyc(1);
        clr = 1'b0;
        cyc(8);
        chk("lit_hang_early", a_hang, 0);
        cyc(1);
        chk("lit_hang_set", a_hang, 1);
        chk("lit_hang_pc", a_hang_pc, 32'h80);
        pc_hold = 1'b0;
        cyc(5);
        chk("lit_hang_sticky", a_hang, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("lit_hang_cleared", a_hang, 0);

        // gated enable, toggling ready, intermittent PC stall
        period = 16'd3;
        for (int i = 0; i < 30; i++) begin
            en = (i % 3) != 0;
            snap_ready = (i % 4) < 2;
            evt = 4'(i);
            pc_hold = (i >= 8 && i < 24);
            cyc(1);
        end

        // period shrinks below the running sample count
        clr = 1'b1; en = 1'b1; pc_hold = 1'b0; snap_ready = 1'b1; period = 16'd8;
        cyc(1);
        clr = 1'b0;
        cyc(6);
        period = 16'd3;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
